// File: rtl/lfsr_sched_pkg.sv
// Shared types and helpers for the LFSR share scheduler and its round-robin arbiter.
// The LFSR word widths supported by fibonacci_lfsr are listed here for elaboration checks.
package lfsr_sched_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } sched_state_t;

  localparam int LEGAL_BITWIDTH [2] = '{20, 64};

  // Index width with a floor of one bit, so single-entry vectors still get a real signal.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fibonacci_lfsr.sv
// Free-running Fibonacci LFSR; out is the current state word, advancing one step per clock.
// Latency: none (registered state is the output). Backpressure: none, it never stalls.
module fibonacci_lfsr #(
  parameter int          BITWIDTH = 64,
  parameter logic [63:0] SEED     = 64'hFEEDBABEDEADBEEF
) (
  input  logic                CLK,
  input  logic                nRST,
  output logic [BITWIDTH-1:0] out
);

  // Maximal-length taps: x^64+x^63+x^61+x^60+1 or x^20+x^17+1.
  localparam logic [BITWIDTH-1:0] TAPS = (BITWIDTH == 64) ? BITWIDTH'(64'hD800_0000_0000_0000)
                                                          : BITWIDTH'(64'h0000_0000_0009_0000);

  logic [BITWIDTH-1:0] lfsr_q;
  logic [BITWIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[BITWIDTH-2:0], ^(lfsr_q & TAPS)};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lfsr_q <= BITWIDTH'(SEED);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign out = lfsr_q;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to index 0.
// Latency: zero cycles. Backpressure: none, the caller owns the pointer.
module rr_arbiter
  import lfsr_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            req,
  input  logic [ptr_width(N)-1:0] ptr,
  output logic [N-1:0]            gnt,
  output logic                    vld
);

  always_comb begin
    gnt = '0;
    vld = 1'b0;
    // Upper segment first; the second pass only fires when nothing at or above ptr is set.
    for (int i = 0; i < N; i++) begin
      if (!vld && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        vld    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!vld && req[i]) begin
        gnt[i] = 1'b1;
        vld    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_share_scheduler.sv
// Shares one free-running LFSR among NUM_REQ requesters; each word goes to one round-robin winner.
// Latency: grant one cycle after request; no grants during warm-up; the LFSR is never stalled.
module lfsr_share_scheduler
  import lfsr_sched_pkg::*;
#(
  parameter int          NUM_REQ       = 4,
  parameter int          BITWIDTH      = 64,
  parameter logic [63:0] SEED          = 64'hFEEDBABEDEADBEEF,
  parameter int          WARMUP_CYCLES = 64
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                clr,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [BITWIDTH-1:0] rnd,
  output logic                rnd_valid,
  output logic                ready
);

  localparam int PW = ptr_width(NUM_REQ);
  localparam int CW = ptr_width(WARMUP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = (WARMUP_CYCLES == 0) ? '0 : CW'(WARMUP_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);

  if (BITWIDTH != LEGAL_BITWIDTH[0] && BITWIDTH != LEGAL_BITWIDTH[1]) begin : g_bad_bitwidth
    $error("lfsr_share_scheduler: BITWIDTH must be 20 or 64");
  end
  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_num_req
    $error("lfsr_share_scheduler: NUM_REQ must be in 1..16");
  end

  logic [BITWIDTH-1:0] lfsr_out;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic                arb_vld;
  logic [PW-1:0]       win_idx;

  sched_state_t        state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [BITWIDTH-1:0] rnd_q, rnd_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic                ready_q, ready_d;

  fibonacci_lfsr #(
    .BITWIDTH (BITWIDTH),
    .SEED     (SEED)
  ) u_lfsr (
    .CLK  (CLK),
    .nRST (nRST),
    .out  (lfsr_out)
  );

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) win_idx = PW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    rnd_d       = rnd_q;
    rnd_valid_d = 1'b0;
    if (clr) begin
      state_d = WARMUP;
      cnt_d   = '0;
      ptr_d   = '0;
    end else if (state_q == WARMUP) begin
      cnt_d = cnt_q + CW'(1);
      if (WARMUP_CYCLES == 0 || cnt_q == CNT_LAST) state_d = RUN;
    end else if (arb_vld) begin
      // The word in flight this cycle goes to the winner; idle cycles simply let it pass.
      gnt_d       = arb_gnt;
      rnd_d       = lfsr_out;
      rnd_valid_d = 1'b1;
      ptr_d       = (win_idx == PTR_LAST) ? '0 : win_idx + PW'(1);
    end
    ready_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= WARMUP;
      cnt_q       <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_lfsr_share_scheduler.sv
// Bench for lfsr_share_scheduler: directed scenarios plus random requester traffic,
// every cycle compared against a behavioural model of the sharing rules.
module tb_lfsr_share_scheduler;

  localparam int          N    = 4;
  localparam int          W    = 8;
  localparam logic [63:0] SEED = 64'hFEEDBABEDEADBEEF;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          clr;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [63:0]   rnd;
  logic          rnd_valid;
  logic          ready;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [63:0]  m_lfsr;
  logic [63:0]  m_rnd;
  logic [N-1:0] m_gnt;
  logic         m_vld;
  logic         m_ready;
  int           m_warm;
  int           m_ptr;
  logic [63:0]  last_rnd;
  logic         last_vld;
  int           wait_cnt [N];
  int           max_wait;

  lfsr_share_scheduler #(
    .NUM_REQ       (N),
    .BITWIDTH      (64),
    .SEED          (SEED),
    .WARMUP_CYCLES (W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr       (clr),
    .req       (req),
    .gnt       (gnt),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .ready     (ready)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Polynomial x^64+x^63+x^61+x^60+1, shifting toward the MSB.
  function automatic logic [63:0] lfsr_next(input logic [63:0] v);
    int   taps [4];
    logic fb;
    taps = '{64, 63, 61, 60};
    fb   = 1'b0;
    foreach (taps[k]) fb = fb ^ v[taps[k]-1];
    return {v[62:0], fb};
  endfunction

  task automatic model_reset();
    m_lfsr   = SEED;
    m_rnd    = '0;
    m_gnt    = '0;
    m_vld    = 1'b0;
    m_ready  = 1'b0;
    m_warm   = 0;
    m_ptr    = 0;
    last_vld = 1'b0;
    foreach (wait_cnt[i]) wait_cnt[i] = 0;
  endtask

  // One clock: drive at negedge, predict, check just after the rising edge, return at negedge.
  task automatic step(input logic [N-1:0] r, input logic c);
    logic was_ready;
    was_ready = m_ready;
    req = r;
    clr = c;
    m_gnt = '0;
    m_vld = 1'b0;
    if (c) begin
      m_ready = 1'b0;
      m_warm  = 0;
      m_ptr   = 0;
    end else if (!m_ready) begin
      m_warm++;
      if (m_warm >= ((W == 0) ? 1 : W)) m_ready = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!m_vld && r[idx]) begin
          m_gnt[idx] = 1'b1;
          m_vld      = 1'b1;
          m_rnd      = m_lfsr;
          m_ptr      = (idx + 1) % N;
        end
      end
    end
    m_lfsr = lfsr_next(m_lfsr);

    @(posedge CLK);
    #1;
    chk("gnt", 64'(gnt), 64'(m_gnt));
    chk("rnd", rnd, m_rnd);
    chk("rnd_valid", 64'(rnd_valid), 64'(m_vld));
    chk("ready", 64'(ready), 64'(m_ready));
    chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    chk("valid_vs_gnt", 64'(rnd_valid), 64'(|gnt));
    if (m_vld && last_vld) chk("rnd_distinct", 64'(rnd != last_rnd), 64'd1);
    if (rnd_valid) begin
      last_rnd = rnd;
      last_vld = 1'b1;
    end

    for (int i = 0; i < N; i++) begin
      if (c || !r[i]) begin
        wait_cnt[i] = 0;
      end else if (was_ready) begin
        wait_cnt[i]++;
        if (gnt[i]) begin
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
          wait_cnt[i] = 0;
        end
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    int           first_rdy;
    int           first_gnt;
    logic [N-1:0] pend;
    logic         c;

    max_wait = 0;
    nRST = 1'b0;
    clr  = 1'b0;
    req  = '0;
    model_reset();
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rnd", rnd, 64'd0);
    chk("rst_rnd_valid", 64'(rnd_valid), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Warm-up length and first grant position with all requesters active
    first_rdy = -1;
    first_gnt = -1;
    for (int s = 1; s <= 12; s++) begin
      step('1, 1'b0);
      if (ready && first_rdy < 0) first_rdy = s;
      if (gnt != '0 && first_gnt < 0) first_gnt = s;
    end
    chk("ready_cycle", 64'(first_rdy), 64'(W));
    chk("first_gnt_cycle", 64'(first_gnt), 64'(W + 1));

    // Full rotation, single requester, sparse pattern, then idle
    repeat (6) step(4'b1111, 1'b0);
    repeat (6) step(4'b0100, 1'b0);
    step(4'b1000, 1'b0);
    repeat (3) step(4'b1010, 1'b0);
    repeat (3) step(4'b0000, 1'b0);

    // Synchronous restart in RUN, LFSR keeps running
    step(4'b0001, 1'b1);
    repeat (12) step(4'b0001, 1'b0);

    // Random requesters that hold until granted and drop in the grant cycle
    pend = '0;
    repeat (400) begin
      c = ($urandom_range(63) == 0);
      step(pend, c);
      pend = pend & ~gnt;
      pend = pend | (N'($urandom) & N'($urandom));
    end
    chk("fairness_bound", 64'(max_wait <= N), 64'd1);

    // Asynchronous reset landing mid-cycle while a grant is being presented
    repeat (3) step(4'b1111, 1'b0);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_gnt", 64'(gnt), 64'd0);
    chk("arst_rnd", rnd, 64'd0);
    chk("arst_rnd_valid", 64'(rnd_valid), 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    repeat (14) step(4'b1111, 1'b0);
    repeat (4) step(4'b0010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_share_scheduler.md
Name: lfsr_share_scheduler

Overview:
Round-robin scheduler that shares one free-running fibonacci_lfsr instance among NUM_REQ stochastic-bitstream requesters. It gates delivery behind a configurable warm-up period after reset or clear. It registers each LFSR word and hands it to exactly one granted requester. It sits between the shared RNG and the per-operator SBitstream generators, so several operators can share one LFSR.

Parameters:
NUM_REQ, 4, number of requesters; legal range 1..16.
BITWIDTH, 64, LFSR word width passed to the LFSR; legal values 20 or 64 only.
SEED, 64'hFEEDBABEDEADBEEF, passed through to the LFSR instance.
WARMUP_CYCLES, 64, LFSR words discarded after reset or clr before the first grant; 0 is legal.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
nRST  input  1  asynchronous, active-low reset; also drives the LFSR instance's nRST.
clr  input  1  synchronous scheduler restart; does not reset the LFSR.
req  input  NUM_REQ  per-requester request, level, held until granted.
gnt  output  NUM_REQ  one-hot grant pulse, registered; at most one bit set.
rnd  output  BITWIDTH  random word delivered with gnt, registered.
rnd_valid  output  1  high exactly when gnt is nonzero.
ready  output  1  high in RUN state; low during warm-up.

Behaviour:
- Reset (nRST=0, asynchronous): gnt=0, rnd=0, rnd_valid=0, ready=0, state=WARMUP, warm-up counter=0, RR pointer=0.
- The LFSR free-runs every cycle; r(t) is its output during cycle t. The scheduler never stalls it.
- State WARMUP: the counter increments each cycle. When the counter reaches WARMUP_CYCLES-1, the next state is RUN. With WARMUP_CYCLES=0, the state goes directly to RUN on the first clock after reset. No grants are issued in WARMUP.
- State RUN: ready=1. Each cycle, the arbiter picks the first set req bit, searching from the RR pointer upward with wrap-around.
  - If a winner i exists: at the next edge gnt=(1<<i), rnd=r(t), rnd_valid=1, and pointer=(i+1) mod NUM_REQ.
  - If no req bit is set: gnt=0 and rnd_valid=0 at the next edge. rnd holds its last value. The pointer is unchanged and r(t) is discarded.
- Latency: a request sampled in cycle t produces its grant in cycle t+1, at the earliest.
- Handshake: a requester deasserts req in the cycle it sees gnt. If req is still high in that cycle, it counts as a new request, arbitrated with the pointer already advanced past it.
- Each LFSR word goes to at most one requester, so consecutive grants always carry distinct consecutive r values.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles of entering RUN.
- clr=1 in any state: at the next edge, state=WARMUP, counter=0, pointer=0, gnt=0, rnd_valid=0, ready=0. rnd holds its last value. clr overrides a grant decision in the same cycle. clr held high keeps the block in WARMUP with counter=0.
- nRST asserted mid-operation: all outputs clear immediately, with no clock edge; any in-flight grant is lost.
- NUM_REQ=1: the pointer is always 0, and gnt equals req delayed one cycle while in RUN.

Decomposition:
- Package lfsr_sched_pkg holds:
  - enum sched_state_t {WARMUP, RUN};
  - function ptr_width(n) returning $clog2 with a floor of 1;
  - constant LEGAL_BITWIDTH check values (20, 64).
- Sub-module rr_arbiter #(N): combinational request vector plus pointer in, one-hot winner and valid out. It is reusable for other shared operators.
- The top instantiates fibonacci_lfsr, rr_arbiter, the state FSM, the warm-up counter and the output registers. An elaboration-time assertion rejects an illegal BITWIDTH.

Test Plan:
1. NUM_REQ=4, WARMUP_CYCLES=8, req=4'b1111 from reset release -> ready=0 and gnt=0 for 8 cycles; ready=1 on cycle 8; first gnt=4'b0001 on cycle 9.
2. req=4'b0100 held in RUN -> gnt=4'b0100 every cycle. rnd equals the golden LFSR model (seed FEEDBABEDEADBEEF) delayed by one cycle, and no value repeats.
3. req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001. rnd_valid=1 on every cycle.
4. Pointer at 0, req=4'b1010 held -> gnt 0010, 1000, 0010. With req=0, gnt=0, rnd_valid=0, rnd stable and the pointer unchanged.
5. clr pulsed for one cycle in RUN while req=4'b0001 -> next cycle gnt=0 and ready=0 for 8 cycles, then gnt=4'b0001. The LFSR sequence continues uninterrupted, checked against the model.
6. nRST dropped asynchronously mid-cycle during a grant -> gnt, rnd, rnd_valid and ready go to 0 before the next edge. After release, warm-up restarts and the LFSR restarts from SEED.
